// File: rtl/sr_sched_pkg.sv
// Shared definitions for the SR flip-flop bank scheduler.
// Holds the command opcode encodings and the scheduler FSM state encoding.
// No logic; imported by sr_bank_scheduler and its arbiter.
package sr_sched_pkg;

  // Per-requester command on the op bus
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SET  = 2'b01,
    OP_RST  = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SETTLE = 2'd2,
    S_CHECK  = 2'd3
  } state_e;

  // True for commands that pulse an S or R line
  function automatic logic is_drive_op(input op_e o);
    return (o == OP_SET) || (o == OP_RST);
  endfunction

endpackage

// File: rtl/sr_bank_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or after ptr, wrapping.
// Latency: purely combinational. Backpressure: none; holders keep req until served.
// Ports: req (requests), ptr (search start) -> gnt (one-hot grant), gid (grant index).
module rr_arbiter #(
  parameter int  NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gid
);

  logic          found;
  logic [PW-1:0] cand;

  always_comb begin
    gnt   = '0;
    gid   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Candidate index walks from ptr upward, wrapping modulo NREQ
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gid       = cand;
      end
    end
  end

endmodule

// File: rtl/sr_bank_scheduler.sv
// Shares one bank of SR flops between NREQ requesters; one S/R pulse, settle, read back, ack.
// Latency: SET/RESET ack 2+SETTLE_CYC cycles after grant sample edge; HOLD/ILLEGAL ack next cycle.
// Backpressure: requesters hold req until their one-cycle ack; one command in flight at a time.
// Ports: clk, rst (async high) | req, op, idx per requester | q_in from bank |
//        s_out, r_out to bank | ack (one-hot), err (valid with ack), busy (not IDLE).
module sr_bank_scheduler
  import sr_sched_pkg::*;
#(
  parameter int  NREQ       = 4,
  parameter int  NBITS      = 8,
  parameter int  SETTLE_CYC = 1,
  localparam int IW         = $clog2(NBITS),
  localparam int PW         = $clog2(NREQ),
  localparam int CW         = $clog2(SETTLE_CYC + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [2*NREQ-1:0]  op,
  input  logic [IW*NREQ-1:0] idx,
  input  logic [NBITS-1:0]   q_in,
  output logic [NBITS-1:0]   s_out,
  output logic [NBITS-1:0]   r_out,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic               busy
);

  state_e        state_q;
  op_e           op_q;
  logic [IW-1:0] idx_q;
  logic [PW-1:0] gid_q;
  logic [PW-1:0] ptr_q;
  logic [CW-1:0] cnt_q;

  logic [NREQ-1:0]  gnt;
  logic [PW-1:0]    gid;
  op_e              sel_op;
  op_e              eff_op;
  logic [IW-1:0]    sel_idx;
  logic             sel_oob;
  logic [NBITS-1:0] sel_mask;
  logic             q_bit;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt),
    .gid (gid)
  );

  // Pick the granted requester's command (gnt is one-hot or zero)
  always_comb begin
    sel_op  = OP_HOLD;
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_op  = op_e'(op[2*i +: 2]);
        sel_idx = idx[IW*i +: IW];
      end
    end
  end

  // Out-of-range bit index only exists when NBITS is not a power of two
  if ((1 << IW) == NBITS) begin : g_idx_full
    assign sel_oob = 1'b0;
  end else begin : g_idx_part
    assign sel_oob = (sel_idx >= IW'(NBITS));
  end

  // An unreachable bit is handled exactly like an ILLEGAL op: nothing driven, err on ack
  assign eff_op   = sel_oob ? OP_ILL : sel_op;
  assign sel_mask = NBITS'(1) << sel_idx;

  // Read-back of the latched target bit; only consulted for in-range SET/RESET
  assign q_bit = |(q_in & (NBITS'(1) << idx_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_HOLD;
      idx_q   <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      s_out   <= '0;
      r_out   <= '0;
      ack     <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      // Pulse-type outputs default low; each state asserts only what it needs
      s_out <= '0;
      r_out <= '0;
      ack   <= '0;
      err   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            gid_q <= gid;
            op_q  <= eff_op;
            idx_q <= sel_idx;
            ptr_q <= (gid == PW'(NREQ - 1)) ? '0 : gid + PW'(1);
            busy  <= 1'b1;
            if (is_drive_op(eff_op)) begin
              state_q <= S_DRIVE;
              if (eff_op == OP_SET) s_out <= sel_mask;
              else                  r_out <= sel_mask;
            end else begin
              // HOLD and ILLEGAL complete without touching the bank
              state_q <= S_CHECK;
              ack     <= gnt;
              err     <= (eff_op == OP_ILL);
            end
          end
        end
        S_DRIVE: begin
          state_q <= S_SETTLE;
          cnt_q   <= CW'(SETTLE_CYC - 1);
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            // Sample q_in now so ack and err appear together on CHECK entry
            state_q <= S_CHECK;
            ack     <= NREQ'(1) << gid_q;
            err     <= (op_q == OP_SET) ? ~q_bit : q_bit;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_CHECK: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank_scheduler.sv
// Self-checking bench for sr_bank_scheduler with a behavioural SR flop bank on s_out/r_out.
// Expected acks are queued when a command is driven and popped when an ack appears.
// A second small instance (NBITS=5) exercises the out-of-range bit index path.
module tb_sr_bank_scheduler;
  import sr_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [2*NREQ-1:0]   op  = '0;
  logic [3*NREQ-1:0]   idx = '0;
  logic [NBITS-1:0]    q_in;
  logic [NBITS-1:0]    s_out, r_out;
  logic [NREQ-1:0]     ack;
  logic                err, busy;

  logic [1:0] req2 = '0;
  logic [3:0] op2  = '0;
  logic [5:0] idx2 = '0;
  logic [4:0] q2   = '0;
  logic [4:0] s2, r2;
  logic [1:0] ack2;
  logic       err2, busy2;

  logic [NBITS-1:0] bank_q     = '0;
  logic [NBITS-1:0] force_zero = '0;

  int tests_run    = 0;
  int tests_failed = 0;
  int inv_viol     = 0;

  typedef struct {
    logic [3:0] ack;
    logic       err;
    int         lat;
    logic [7:0] s;
    logic [7:0] r;
    int         drv;
  } exp_t;
  exp_t sb[$];

  sr_bank_scheduler #(.NREQ(NREQ), .NBITS(NBITS), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx), .q_in(q_in),
    .s_out(s_out), .r_out(r_out), .ack(ack), .err(err), .busy(busy)
  );

  sr_bank_scheduler #(.NREQ(2), .NBITS(5), .SETTLE_CYC(1)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .op(op2), .idx(idx2), .q_in(q2),
    .s_out(s2), .r_out(r2), .ack(ack2), .err(err2), .busy(busy2)
  );

  always #10 clk = ~clk;

  // Master-slave SR flop bank: captures S/R at the rising edge
  always @(posedge clk) begin
    for (int i = 0; i < NBITS; i++) begin
      if (s_out[i] && !r_out[i])      bank_q[i] <= 1'b1;
      else if (r_out[i] && !s_out[i]) bank_q[i] <= 1'b0;
      else if (s_out[i] && r_out[i])  bank_q[i] <= 1'bx;
    end
  end
  assign q_in = bank_q & ~force_zero;

  // Never S and R together, never more than one line active
  always @(negedge clk) begin
    if ((s_out & r_out) != '0 || $countones(s_out | r_out) > 1) inv_viol++;
    if ((s2 & r2) != '0 || $countones(s2 | r2) > 1) inv_viol++;
  end

  task automatic set_req(input int i, input logic [1:0] o, input logic [2:0] ix);
    op[2*i +: 2]  = o;
    idx[3*i +: 3] = ix;
    req[i]        = 1'b1;
  endtask

  task automatic sb_push(input logic [3:0] a, input logic e, input int l,
                         input logic [7:0] s, input logic [7:0] r, input int d);
    exp_t x;
    x.ack = a; x.err = e; x.lat = l; x.s = s; x.r = r; x.drv = d;
    sb.push_back(x);
  endtask

  // Waits (bounded) for an ack on either instance, collecting what was driven meanwhile
  task automatic wait_ack(input bit use2, input int budget, output int lat,
                          output logic [7:0] ss, output logic [7:0] rs, output int drv,
                          output logic [3:0] ag, output logic eg);
    int n;
    logic [3:0] ca;
    logic [7:0] cs, cr;
    logic ce;
    lat = -1; ss = '0; rs = '0; drv = 0; ag = '0; eg = 1'b0; n = 0;
    while (lat < 0 && n < budget) begin
      @(negedge clk);
      n++;
      ca = use2 ? {2'b00, ack2} : ack;
      cs = use2 ? {3'b000, s2} : s_out;
      cr = use2 ? {3'b000, r2} : r_out;
      ce = use2 ? err2 : err;
      ss |= cs;
      rs |= cr;
      if ((cs | cr) != 8'h00) drv++;
      if (ca != 4'h0) begin lat = n; ag = ca; eg = ce; end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    int lat, drv; logic [7:0] ss, rs; logic [3:0] ag; logic eg; exp_t e;
    #1 rst = 1'b1;
    #5;
    tests_run++; if (s_out !== 8'h00) begin tests_failed++; $display("FAIL reset_s_out: got %h, want 00", s_out); end
    tests_run++; if (r_out !== 8'h00) begin tests_failed++; $display("FAIL reset_r_out: got %h, want 00", r_out); end
    tests_run++; if (ack !== 4'h0) begin tests_failed++; $display("FAIL reset_ack: got %b, want 0000", ack); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b, want 0", err); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, want 0", busy); end
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    // Single SET of bit 3 from requester 0
    set_req(0, OP_SET, 3'd3);
    sb_push(4'b0001, 1'b0, 3, 8'h08, 8'h00, 1);
    wait_ack(1'b0, 10, lat, ss, rs, drv, ag, eg);
    req[0] = 1'b0;
    e = sb.pop_front();
    tests_run++; if (ag !== e.ack) begin tests_failed++; $display("FAIL set_ack: got %b, want %b", ag, e.ack); end
    tests_run++; if (eg !== e.err) begin tests_failed++; $display("FAIL set_err: got %b, want %b", eg, e.err); end
    tests_run++; if (lat != e.lat) begin tests_failed++; $display("FAIL set_latency: got %0d, want %0d", lat, e.lat); end
    tests_run++; if (ss !== e.s) begin tests_failed++; $display("FAIL set_s_out: got %h, want %h", ss, e.s); end
    tests_run++; if (rs !== e.r) begin tests_failed++; $display("FAIL set_r_out: got %h, want %h", rs, e.r); end
    tests_run++; if (drv != e.drv) begin tests_failed++; $display("FAIL set_drive_cycles: got %0d, want %0d", drv, e.drv); end
    @(negedge clk);
    tests_run++; if (ack !== 4'h0) begin tests_failed++; $display("FAIL set_ack_pulse: got %b, want 0000", ack); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL set_busy_after: got %b, want 0", busy); end
    tests_run++; if (bank_q[3] !== 1'b1) begin tests_failed++; $display("FAIL set_bank_q3: got %b, want 1", bank_q[3]); end
  endtask

  task automatic test_reset_bit();
    int lat, drv; logic [7:0] ss, rs; logic [3:0] ag; logic eg; exp_t e;
    set_req(2, OP_RST, 3'd3);
    sb_push(4'b0100, 1'b0, 3, 8'h00, 8'h08, 1);
    wait_ack(1'b0, 10, lat, ss, rs, drv, ag, eg);
    req[2] = 1'b0;
    e = sb.pop_front();
    tests_run++; if (ag !== e.ack) begin tests_failed++; $display("FAIL rst_ack: got %b, want %b", ag, e.ack); end
    tests_run++; if (eg !== e.err) begin tests_failed++; $display("FAIL rst_err: got %b, want %b", eg, e.err); end
    tests_run++; if (lat != e.lat) begin tests_failed++; $display("FAIL rst_latency: got %0d, want %0d", lat, e.lat); end
    tests_run++; if (ss !== e.s) begin tests_failed++; $display("FAIL rst_s_out: got %h, want %h", ss, e.s); end
    tests_run++; if (rs !== e.r) begin tests_failed++; $display("FAIL rst_r_out: got %h, want %h", rs, e.r); end
    tests_run++; if (drv != e.drv) begin tests_failed++; $display("FAIL rst_drive_cycles: got %0d, want %0d", drv, e.drv); end
    @(negedge clk);
    tests_run++; if (bank_q[3] !== 1'b0) begin tests_failed++; $display("FAIL rst_bank_q3: got %b, want 0", bank_q[3]); end
  endtask

  task automatic test_round_robin();
    int lat, drv; logic [7:0] ss, rs; logic [3:0] ag; logic eg; exp_t e;
    reset_dut();
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, OP_SET, 3'(i));
      // First service waits for DRIVE+SETTLE; later ones add the IDLE hop back
      sb_push(4'(1 << i), 1'b0, (i == 0) ? 3 : 4, 8'(1 << i), 8'h00, 1);
    end
    for (int j = 0; j < NREQ; j++) begin
      wait_ack(1'b0, 10, lat, ss, rs, drv, ag, eg);
      req = req & ~ag;
      e = sb.pop_front();
      tests_run++; if (ag !== e.ack) begin tests_failed++; $display("FAIL rr%0d_ack: got %b, want %b", j, ag, e.ack); end
      tests_run++; if (eg !== e.err) begin tests_failed++; $display("FAIL rr%0d_err: got %b, want %b", j, eg, e.err); end
      tests_run++; if (lat != e.lat) begin tests_failed++; $display("FAIL rr%0d_latency: got %0d, want %0d", j, lat, e.lat); end
      tests_run++; if (ss !== e.s) begin tests_failed++; $display("FAIL rr%0d_s_out: got %h, want %h", j, ss, e.s); end
      tests_run++; if (rs !== e.r) begin tests_failed++; $display("FAIL rr%0d_r_out: got %h, want %h", j, rs, e.r); end
      tests_run++; if (drv != e.drv) begin tests_failed++; $display("FAIL rr%0d_drive_cycles: got %0d, want %0d", j, drv, e.drv); end
    end
    req = '0;
    @(negedge clk);
    tests_run++; if (bank_q[3:0] !== 4'hF) begin tests_failed++; $display("FAIL rr_bank: got %h, want f", bank_q[3:0]); end
  endtask

  task automatic test_illegal();
    int lat, drv; logic [7:0] ss, rs; logic [3:0] ag; logic eg; exp_t e;
    // ILLEGAL opcode
    set_req(1, OP_ILL, 3'd2);
    sb_push(4'b0010, 1'b1, 1, 8'h00, 8'h00, 0);
    wait_ack(1'b0, 10, lat, ss, rs, drv, ag, eg);
    req[1] = 1'b0;
    e = sb.pop_front();
    tests_run++; if (ag !== e.ack) begin tests_failed++; $display("FAIL ill_ack: got %b, want %b", ag, e.ack); end
    tests_run++; if (eg !== e.err) begin tests_failed++; $display("FAIL ill_err: got %b, want %b", eg, e.err); end
    tests_run++; if (lat != e.lat) begin tests_failed++; $display("FAIL ill_latency: got %0d, want %0d", lat, e.lat); end
    tests_run++; if (drv != e.drv) begin tests_failed++; $display("FAIL ill_drive_cycles: got %0d, want %0d", drv, e.drv); end
    @(negedge clk);
    // HOLD completes immediately without error
    set_req(3, OP_HOLD, 3'd4);
    sb_push(4'b1000, 1'b0, 1, 8'h00, 8'h00, 0);
    wait_ack(1'b0, 10, lat, ss, rs, drv, ag, eg);
    req[3] = 1'b0;
    e = sb.pop_front();
    tests_run++; if (ag !== e.ack) begin tests_failed++; $display("FAIL hold_ack: got %b, want %b", ag, e.ack); end
    tests_run++; if (eg !== e.err) begin tests_failed++; $display("FAIL hold_err: got %b, want %b", eg, e.err); end
    tests_run++; if (lat != e.lat) begin tests_failed++; $display("FAIL hold_latency: got %0d, want %0d", lat, e.lat); end
    tests_run++; if (drv != e.drv) begin tests_failed++; $display("FAIL hold_drive_cycles: got %0d, want %0d", drv, e.drv); end
    @(negedge clk);
    tests_run++; if (bank_q !== 8'h0F) begin tests_failed++; $display("FAIL hold_bank: got %h, want 0f", bank_q); end
    // Out-of-range index (7 on a 5-bit bank) behaves as ILLEGAL even with op SET
    req2[1] = 1'b1; op2[3:2] = OP_SET; idx2[5:3] = 3'd7;
    sb_push(4'b0010, 1'b1, 1, 8'h00, 8'h00, 0);
    wait_ack(1'b1, 10, lat, ss, rs, drv, ag, eg);
    req2[1] = 1'b0;
    e = sb.pop_front();
    tests_run++; if (ag !== e.ack) begin tests_failed++; $display("FAIL oob_ack: got %b, want %b", ag, e.ack); end
    tests_run++; if (eg !== e.err) begin tests_failed++; $display("FAIL oob_err: got %b, want %b", eg, e.err); end
    tests_run++; if (lat != e.lat) begin tests_failed++; $display("FAIL oob_latency: got %0d, want %0d", lat, e.lat); end
    tests_run++; if (drv != e.drv) begin tests_failed++; $display("FAIL oob_drive_cycles: got %0d, want %0d", drv, e.drv); end
    @(negedge clk);
    tests_run++; if (busy2 !== 1'b0) begin tests_failed++; $display("FAIL oob_busy_after: got %b, want 0", busy2); end
    // In-range RESET on the small bank still drives and reads back (q tied low)
    req2[0] = 1'b1; op2[1:0] = OP_RST; idx2[2:0] = 3'd4;
    sb_push(4'b0001, 1'b0, 3, 8'h00, 8'h10, 1);
    wait_ack(1'b1, 10, lat, ss, rs, drv, ag, eg);
    req2[0] = 1'b0;
    e = sb.pop_front();
    tests_run++; if (ag !== e.ack) begin tests_failed++; $display("FAIL inrange_ack: got %b, want %b", ag, e.ack); end
    tests_run++; if (eg !== e.err) begin tests_failed++; $display("FAIL inrange_err: got %b, want %b", eg, e.err); end
    tests_run++; if (lat != e.lat) begin tests_failed++; $display("FAIL inrange_latency: got %0d, want %0d", lat, e.lat); end
    tests_run++; if (rs !== e.r) begin tests_failed++; $display("FAIL inrange_r_out: got %h, want %h", rs, e.r); end
    @(negedge clk);
  endtask

  task automatic test_mismatch();
    int lat, drv; logic [7:0] ss, rs; logic [3:0] ag; logic eg; exp_t e;
    force_zero = 8'h20;
    set_req(0, OP_SET, 3'd5);
    sb_push(4'b0001, 1'b1, 3, 8'h20, 8'h00, 1);
    wait_ack(1'b0, 10, lat, ss, rs, drv, ag, eg);
    req[0] = 1'b0;
    e = sb.pop_front();
    tests_run++; if (ag !== e.ack) begin tests_failed++; $display("FAIL mis_ack: got %b, want %b", ag, e.ack); end
    tests_run++; if (eg !== e.err) begin tests_failed++; $display("FAIL mis_err: got %b, want %b", eg, e.err); end
    tests_run++; if (lat != e.lat) begin tests_failed++; $display("FAIL mis_latency: got %0d, want %0d", lat, e.lat); end
    tests_run++; if (ss !== e.s) begin tests_failed++; $display("FAIL mis_s_out: got %h, want %h", ss, e.s); end
    force_zero = 8'h00;
    @(negedge clk);
    tests_run++; if (bank_q[5] !== 1'b1) begin tests_failed++; $display("FAIL mis_bank_q5: got %b, want 1", bank_q[5]); end
  endtask

  task automatic test_reset_mid_drive();
    int lat, drv; logic [7:0] ss, rs; logic [3:0] ag; logic eg; exp_t e;
    set_req(1, OP_SET, 3'd6);
    @(negedge clk);
    tests_run++; if (s_out !== 8'h40) begin tests_failed++; $display("FAIL mid_drive_s_out: got %h, want 40", s_out); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL mid_drive_busy: got %b, want 1", busy); end
    #5 rst = 1'b1;
    #1;
    tests_run++; if (s_out !== 8'h00) begin tests_failed++; $display("FAIL async_s_out: got %h, want 00", s_out); end
    tests_run++; if (r_out !== 8'h00) begin tests_failed++; $display("FAIL async_r_out: got %h, want 00", r_out); end
    tests_run++; if (ack !== 4'h0) begin tests_failed++; $display("FAIL async_ack: got %b, want 0000", ack); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL async_busy: got %b, want 0", busy); end
    req = '0;
    @(negedge clk); rst = 1'b0;
    // All request at once: pointer must be back at 0
    for (int i = 0; i < NREQ; i++) set_req(i, OP_HOLD, 3'(i));
    sb_push(4'b0001, 1'b0, 1, 8'h00, 8'h00, 0);
    wait_ack(1'b0, 10, lat, ss, rs, drv, ag, eg);
    req = '0;
    e = sb.pop_front();
    tests_run++; if (ag !== e.ack) begin tests_failed++; $display("FAIL post_reset_ack: got %b, want %b", ag, e.ack); end
    tests_run++; if (lat != e.lat) begin tests_failed++; $display("FAIL post_reset_latency: got %0d, want %0d", lat, e.lat); end
    @(negedge clk);
    tests_run++; if (bank_q[6] !== 1'b0) begin tests_failed++; $display("FAIL post_reset_bank_q6: got %b, want 0", bank_q[6]); end
  endtask

  task automatic test_invariant();
    repeat (3) @(negedge clk);
    tests_run++; if (inv_viol != 0) begin tests_failed++; $display("FAIL sr_invariant: got %0d violations, want 0", inv_viol); end
    tests_run++; if (sb.size() != 0) begin tests_failed++; $display("FAIL scoreboard_empty: got %0d left, want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_reset_bit();
    test_round_robin();
    test_illegal();
    test_mismatch();
    test_reset_mid_drive();
    test_invariant();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
